// File: rtl/golomb_run_scheduler.sv
// rtl/golomb_run_scheduler.sv - zero-run counter that emits Golomb-Rice codewords serially, MSB first
module golomb_run_scheduler #(
    parameter int CNT_W   = 8,
    parameter int MAX_RUN = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] k,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);
    localparam int NW = (CNT_W > 8) ? CNT_W : 8;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        UNARY = 2'd1,
        SEP   = 2'd2,
        REM   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_alive;
    logic [CNT_W-1:0] r_run;
    logic [CNT_W-1:0] w_run_nxt;
    logic [2:0]       r_kq;
    logic [NW-1:0]    r_q;
    logic [7:0]       r_r;
    logic [2:0]       r_idx;

    logic             w_accept;
    logic             w_xfer;
    logic             w_cap;
    logic [NW-1:0]    w_n;
    logic [NW-1:0]    w_q;
    logic [7:0]       w_mask;
    logic [7:0]       w_r;

    assign in_ready  = r_alive && (r_state == COUNT);
    assign busy      = (r_state != COUNT);
    assign out_valid = (r_state != COUNT);
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = out_valid && out_ready;

    // A bit accepted alongside flush wins; flush only closes a non-empty run.
    always_comb begin
        w_cap     = 1'b0;
        w_n       = '0;
        w_run_nxt = r_run;
        if (w_accept) begin
            if (in_bit) begin
                w_cap     = 1'b1;
                w_n       = NW'(r_run);
                w_run_nxt = '0;
            end else if (r_run == CNT_W'(MAX_RUN - 1)) begin
                w_cap     = 1'b1;
                w_n       = NW'(MAX_RUN);
                w_run_nxt = '0;
            end else begin
                w_run_nxt = r_run + 1'b1;
            end
        end else if (flush && (r_state == COUNT) && (r_run != '0)) begin
            w_cap     = 1'b1;
            w_n       = NW'(r_run);
            w_run_nxt = '0;
        end
    end

    assign w_mask = (8'd1 << k) - 8'd1;
    assign w_r    = w_n[7:0] & w_mask;
    assign w_q    = w_n >> k;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COUNT: begin
                if (w_cap) begin
                    w_state_nxt = (w_q != '0) ? UNARY : SEP;
                end
            end
            UNARY: begin
                if (w_xfer && (r_q == NW'(1))) begin
                    w_state_nxt = SEP;
                end
            end
            SEP: begin
                if (w_xfer) begin
                    w_state_nxt = (r_kq != 3'd0) ? REM : COUNT;
                end
            end
            REM: begin
                if (w_xfer && (r_idx == 3'd0)) begin
                    w_state_nxt = COUNT;
                end
            end
            default: w_state_nxt = COUNT;
        endcase
    end

    always_comb begin
        out_bit  = 1'b0;
        out_last = 1'b0;
        case (r_state)
            UNARY: out_bit = 1'b1;
            SEP:   out_last = (r_kq == 3'd0);
            REM: begin
                out_bit  = r_r[r_idx];
                out_last = (r_idx == 3'd0);
            end
            default: begin
                out_bit  = 1'b0;
                out_last = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive <= 1'b0;
            r_run   <= '0;
            r_kq    <= 3'd0;
            r_q     <= '0;
            r_r     <= 8'd0;
            r_idx   <= 3'd0;
        end else begin
            r_alive <= 1'b1;
            r_run   <= w_run_nxt;
            if (w_cap) begin
                r_kq <= k;
                r_q  <= w_q;
                r_r  <= w_r;
            end else if (w_xfer) begin
                case (r_state)
                    UNARY:   r_q   <= r_q - 1'b1;
                    SEP:     r_idx <= r_kq - 3'd1;
                    REM:     r_idx <= r_idx - 3'd1;
                    default: r_idx <= r_idx;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_golomb_run_scheduler.sv
// tb/tb_golomb_run_scheduler.sv - directed self-checking bench for golomb_run_scheduler
module tb_golomb_run_scheduler;
    logic       clk;
    logic       rst_n;
    logic [2:0] k;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;

    int n_tests;
    int n_fail;

    golomb_run_scheduler #(.CNT_W(8), .MAX_RUN(255)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .k         (k),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the bit is sampled on the following posedge.
    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send(1'b0);
    endtask

    // Codeword bits MSB first, exp[len-1] is the first bit; out_ready held high.
    task automatic expect_code(input string tag, input int len, input logic [31:0] exp);
        for (int i = 0; i < len; i++) begin
            check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_bit"}, {31'd0, out_bit}, {31'd0, exp[len-1-i]});
            check({tag, "_last"}, {31'd0, out_last}, (i == len - 1) ? 32'd1 : 32'd0);
            check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        check({tag, "_done"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int idx;
        logic [3:0] exp_flush;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        k         = 3'd0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_inrdy", {31'd0, in_ready}, 32'd0);
        check("rst_bit", {31'd0, out_bit}, 32'd0);
        check("rst_last", {31'd0, out_last}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_inrdy0", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("rel_inrdy1", {31'd0, in_ready}, 32'd1);

        // N=5, k=2
        k = 3'd2;
        send_zeros(5);
        check("run5_idle", {31'd0, out_valid}, 32'd0);
        send(1'b1);
        expect_code("k2_n5", 4, 32'b1001);

        // N=0, k=3
        k = 3'd3;
        send(1'b1);
        expect_code("k3_n0", 4, 32'b0000);

        // N=3, k=0
        k = 3'd0;
        send_zeros(3);
        send(1'b1);
        expect_code("k0_n3", 4, 32'b1110);

        // saturation
        k = 3'd7;
        send_zeros(254);
        check("sat_pre_valid", {31'd0, out_valid}, 32'd0);
        send(1'b0);
        expect_code("sat", 9, 32'b101111111);
        k = 3'd0;
        send(1'b1);
        expect_code("sat_next", 1, 32'b0);

        // flush closes a run of 6, out_ready stalls
        k = 3'd2;
        send_zeros(6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_flush = 4'b1010;
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            out_ready = ((c % 3) == 0);
            check("fl_valid", {31'd0, out_valid}, 32'd1);
            check("fl_bit", {31'd0, out_bit}, {31'd0, exp_flush[3-idx]});
            check("fl_last", {31'd0, out_last}, (idx == 3) ? 32'd1 : 32'd0);
            check("fl_inrdy", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            if (out_ready) idx++;
        end
        out_ready = 1'b1;
        check("fl_count", idx, 32'd4);
        check("fl_done", {31'd0, out_valid}, 32'd0);

        // flush with empty run is ignored
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_empty", {31'd0, out_valid}, 32'd0);

        // accepted bit beats flush in the same cycle
        k = 3'd0;
        send(1'b0);
        flush = 1'b1;
        send(1'b0);
        flush = 1'b0;
        check("fl_prio", {31'd0, out_valid}, 32'd0);
        send(1'b1);
        expect_code("fl_prio_code", 3, 32'b110);

        // reset mid-codeword
        k = 3'd1;
        send_zeros(4);
        send(1'b1);
        check("ab_unary", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("ab_valid", {31'd0, out_valid}, 32'd0);
        check("ab_busy", {31'd0, busy}, 32'd0);
        check("ab_bit", {31'd0, out_bit}, 32'd0);
        check("ab_inrdy", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ab_idle", {31'd0, out_valid}, 32'd0);
        k = 3'd1;
        send(1'b0);
        send(1'b1);
        expect_code("ab_code", 2, 32'b01);

        // k change during emission
        k = 3'd2;
        send_zeros(5);
        send(1'b1);
        k = 3'd5;
        expect_code("kq_old", 4, 32'b1001);
        send_zeros(5);
        send(1'b1);
        expect_code("kq_new", 6, 32'b000101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/golomb_run_scheduler.md
GOLOMB_RUN_SCHEDULER -- requirements
Module: golomb_run_scheduler

Interface
REQ-001 Parameter CNT_W, default 8, width of the zero-run counter.
REQ-002 Parameter MAX_RUN, default 255, run length that forces a saturation codeword; SHALL be <= 2^CNT_W - 1.
REQ-003 Port clk  input  1  rising-edge clock, single clock domain.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port k  input  3  Rice parameter; divisor m = 2^k (k = 0..7).
REQ-006 Port in_bit  input  1  input stream bit; 0 extends the run, 1 terminates it.
REQ-007 Port in_valid  input  1  in_bit is valid.
REQ-008 Port in_ready  output  1  scheduler accepts in_bit this cycle.
REQ-009 Port flush  input  1  single-cycle request to close the current run without a terminating 1.
REQ-010 Port out_bit  output  1  serial codeword bit, MSB first.
REQ-011 Port out_valid  output  1  out_bit is valid.
REQ-012 Port out_ready  input  1  downstream accepts out_bit.
REQ-013 Port out_last  output  1  out_bit is the final bit of the current codeword.
REQ-014 Port busy  output  1  codeword emission in progress.

Function
REQ-015 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-016 FSM states SHALL be COUNT, UNARY, SEP, REM; in_ready SHALL be 1 only in COUNT; busy SHALL be 1 in all states except COUNT.
REQ-017 In COUNT, an accepted 0 with run < MAX_RUN-1 SHALL increment run.
REQ-018 In COUNT, an accepted 0 with run = MAX_RUN-1 SHALL capture N = MAX_RUN, clear run, and start emission (saturation codeword, no terminator consumed).
REQ-019 In COUNT, an accepted 1 SHALL capture N = run, clear run, and start emission; N = 0 is legal.
REQ-020 flush in COUNT with run > 0 and no accepted bit SHALL capture N = run and start emission; flush with run = 0 SHALL be ignored; flush outside COUNT SHALL be ignored.
REQ-021 A bit accepted in the same cycle as flush SHALL take priority; flush is dropped that cycle.
REQ-022 On capture, k SHALL be latched as kq; q = N >> kq and r = N mod 2^kq SHALL be fixed for the whole codeword; later changes of k do not affect it.
REQ-023 Emission order SHALL be: q ones (UNARY), one 0 (SEP), then kq remainder bits of r MSB first (REM).
REQ-024 Start of emission SHALL enter UNARY if q > 0, else SEP; SEP SHALL go to REM if kq > 0, else return to COUNT.
REQ-025 The state and bit index SHALL advance only on an output transfer; out_bit, out_valid and out_last SHALL hold stable while out_ready is low.
REQ-026 out_last SHALL be 1 on the SEP bit when kq = 0, otherwise on the final REM bit; after that transfer the FSM SHALL return to COUNT.
REQ-027 Latency: the first codeword bit SHALL be valid on the cycle after the capturing cycle; out_valid SHALL be 1 in UNARY, SEP and REM and 0 in COUNT.
REQ-028 The codeword length in bits SHALL be q + 1 + kq, with no idle cycles between bits while out_ready is held high.

Reset
REQ-029 rst_n low SHALL asynchronously force state COUNT, run = 0, kq = 0, out_valid = 0, out_bit = 0, out_last = 0, busy = 0, in_ready = 0.
REQ-030 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted mid-codeword SHALL abort the codeword; no partial bits SHALL be emitted after release.

Verification
REQ-032 k=2, bits 0,0,0,0,0,1, out_ready=1 -> N=5, q=1, r=1 -> out 1,0,0,1; out_last on the 4th bit only.
REQ-033 k=3, bit 1 only -> N=0 -> out 0,0,0,0; k=0 with bits 0,0,0,1 -> out 1,1,1,0, with out_last on the 0.
REQ-034 k=7, 255 consecutive 0s -> saturation with N=255, q=1, r=127 -> out 1,0,1,1,1,1,1,1,1; next run starts at 0 with no 1 consumed.
REQ-035 k=2, run 6 closed by flush, out_ready toggling 1,0,0,1,... -> out 1,0,1,0; bits held stable while out_ready=0; in_ready=0 throughout emission.
REQ-036 Assert rst_n during the UNARY state -> outputs cleared immediately; after release, bits 0,1 with k=1 -> out 0,1 only.
REQ-037 k changed from 2 to 5 during emission of a k=2 codeword -> that codeword uses kq=2; the next codeword uses kq=5.
